// File: rtl/spi_recv.sv
// SPI mode-0 slave receiver: synchronizes the SPI pins into the aclk domain, assembles
// MSB-first bytes and emits them through a small FIFO as an AXI4-Stream master.
module spi_recv #(
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned SyncStages = 2
) (
  input  logic       axi_aclk_i,
  input  logic       axi_aresetn_i,
  input  logic       spi_clk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_i,
  output logic       axis_tvalid_o,
  input  logic       axis_tready_i,
  output logic [7:0] axis_tdata_o,
  output logic       axis_tlast_o,
  output logic       overflow_o,
  output logic       frame_err_o
);

  localparam int unsigned AddrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  localparam logic [1:0] StWaitIdle = 2'd0;
  localparam logic [1:0] StIdle     = 2'd1;
  localparam logic [1:0] StShift    = 2'd2;

  // cs syncs reset to 0 so a frame already open at reset exit is held off in StWaitIdle.
  logic [SyncStages-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                  sclk_prev_q;
  logic                  sclk_s, mosi_s, cs_s, sclk_rise;

  always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
    if (!axi_aresetn_i) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], spi_clk_i};
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], spi_mosi_i};
      cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi_cs_i};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SyncStages-1];
  assign mosi_s    = mosi_sync_q[SyncStages-1];
  assign cs_s      = cs_sync_q[SyncStages-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, pend_q, pend_d, new_byte;
  logic       pend_vld_q, pend_vld_d;
  logic       frame_err_q, frame_err_d;
  logic       push;
  logic [8:0] push_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    new_byte    = {shift_q[6:0], mosi_s};
    case (state_q)
      StWaitIdle: if (cs_s) state_d = StIdle;
      StIdle: begin
        if (!cs_s) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // A clock rise wins; a coincident cs rise is still seen next cycle and closes the frame.
        if (sclk_rise) begin
          shift_d = new_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            push       = pend_vld_q;
            push_data  = {1'b0, pend_q};
            pend_d     = new_byte;
            pend_vld_d = 1'b1;
          end
        end else if (cs_s) begin
          frame_err_d = (cnt_q != 3'd0);
          push        = pend_vld_q;
          push_data   = {1'b1, pend_q};
          pend_vld_d  = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
    if (!axi_aresetn_i) begin
      state_q     <= StWaitIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  logic [8:0]       mem_q [FifoDepth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             overflow_q, full, pop, push_ok;

  assign full    = (count_q == (AddrW+1)'(FifoDepth));
  assign pop     = (count_q != '0) & axis_tready_i;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
    if (!axi_aresetn_i) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AddrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (push_ok && !pop) count_q <= count_q + (AddrW+1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (AddrW+1)'(1);
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign axis_tvalid_o = (count_q != '0);
  assign axis_tdata_o  = mem_q[rd_ptr_q][7:0];
  assign axis_tlast_o  = mem_q[rd_ptr_q][8];
  assign overflow_o    = overflow_q;
  assign frame_err_o   = frame_err_q;

endmodule
